// File: rtl/opl3_clk_en_gen_frac.sv
// ---------------------------------------------------------------------------
// opl3_clk_en_gen_frac
//
// Multi-channel fractional clock-enable generator. Each channel owns a phase
// accumulator that adds its increment on every running cycle. The carry out
// of the top bit becomes a registered single-cycle enable pulse, so the
// average pulse rate is clk * inc / 2^ACC_WIDTH and is exact even when the
// ratio is not an integer.
//
// A new increment is written into a per-channel holding register first. It
// is moved into the live increment only at a safe moment, so no period is
// ever cut short or stretched:
//   - on the channel's carry, which is the period boundary,
//   - while the channel is stopped (run = 0), or
//   - on a global restart.
// The sum in the cycle that applies the new value still uses the old
// increment.
//
// Ports:
//   clk          master clock
//   reset_n      asynchronous active-low reset
//   run          per-channel accumulate enable; 0 holds phase
//   restart      synchronous phase restart of every channel. It zeroes all
//                accumulators, suppresses pulses for that cycle and applies
//                any pending increment. It has priority over run and carry.
//   wr_en        increment write strobe
//   wr_chan      target channel of the write; out-of-range is ignored
//   wr_data      new increment value
//   clk_en       registered enable pulses, one bit per channel
//   inc_pending  a written increment is waiting to be applied
// ---------------------------------------------------------------------------
module opl3_clk_en_gen_frac #(
  parameter int NUM_CHANNELS   = 2,
  parameter int ACC_WIDTH      = 24,
  parameter int DEFAULT_INC    = 65536,
  parameter int CHAN_SEL_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CHANNELS-1:0]   run,
  input  logic                      restart,
  input  logic                      wr_en,
  input  logic [CHAN_SEL_WIDTH-1:0] wr_chan,
  input  logic [ACC_WIDTH-1:0]      wr_data,
  output logic [NUM_CHANNELS-1:0]   clk_en,
  output logic [NUM_CHANNELS-1:0]   inc_pending
);

  localparam logic [ACC_WIDTH-1:0] RESET_INC = ACC_WIDTH'(DEFAULT_INC);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    // Address of this channel. Codes at or above NUM_CHANNELS never match
    // any channel, so out-of-range writes fall through untouched.
    localparam logic [CHAN_SEL_WIDTH-1:0] CHAN_ID = CHAN_SEL_WIDTH'(c);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] inc_q;
    logic [ACC_WIDTH-1:0] pend_q;
    logic                 pend_valid_q;
    logic                 en_q;

    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 apply;
    logic                 wr_hit;

    // One extra bit holds the wrap-around carry.
    assign sum    = {1'b0, acc_q} + {1'b0, inc_q};

    // A carry only counts when the channel really accumulates this cycle.
    assign carry  = run[c] & ~restart & sum[ACC_WIDTH];

    // The pending value is swapped in only at a period boundary, or while
    // the phase is frozen or being reset anyway.
    assign apply  = pend_valid_q & (restart | ~run[c] | carry);

    assign wr_hit = wr_en & (wr_chan == CHAN_ID);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_q        <= '0;
        inc_q        <= RESET_INC;
        pend_q       <= '0;
        pend_valid_q <= 1'b0;
        en_q         <= 1'b0;
      end else begin
        // Phase accumulator and pulse register.
        if (restart) begin
          acc_q <= '0;
          en_q  <= 1'b0;
        end else if (run[c]) begin
          acc_q <= sum[ACC_WIDTH-1:0];
          en_q  <= sum[ACC_WIDTH];
        end else begin
          en_q  <= 1'b0;
        end

        // Increment hand-over. A write that lands in the same cycle as an
        // apply is ordered after it: the old pending value goes live and the
        // new data becomes the next pending value.
        if (apply) begin
          inc_q        <= pend_q;
          pend_valid_q <= 1'b0;
        end
        if (wr_hit) begin
          pend_q       <= wr_data;
          pend_valid_q <= 1'b1;
        end
      end
    end

    assign clk_en[c]      = en_q;
    assign inc_pending[c] = pend_valid_q;
  end

endmodule

// File: tb/tb_opl3_clk_en_gen_frac.sv
// ---------------------------------------------------------------------------
// Bench for opl3_clk_en_gen_frac.
//
// Two instances share the clock and reset:
//   dut_a : default parameters (2 channels, 24-bit accumulator, inc 65536)
//   dut_b : 3 channels, 4-bit accumulator, default inc 4
//
// A cycle-level reference model derives every output from the behavioural
// rules with plain integer arithmetic. A compare process checks it against
// both instances on every falling edge. Directed sequences add literal,
// hand-derived pulse positions that pin the model. Cycle k means the sample
// taken after the k-th accumulating clock edge that follows a reset release
// or restart.
// ---------------------------------------------------------------------------
module tb_opl3_clk_en_gen_frac;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (defaults) ----------------
  logic [1:0]  run_a = '0;
  logic        restart_a = 1'b0;
  logic        wr_en_a = 1'b0;
  logic [0:0]  wr_chan_a = '0;
  logic [23:0] wr_data_a = '0;
  logic [1:0]  clk_en_a;
  logic [1:0]  inc_pending_a;

  opl3_clk_en_gen_frac dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run_a),
    .restart     (restart_a),
    .wr_en       (wr_en_a),
    .wr_chan     (wr_chan_a),
    .wr_data     (wr_data_a),
    .clk_en      (clk_en_a),
    .inc_pending (inc_pending_a)
  );

  // ---------------- DUT B (small accumulator) ----------------
  logic [2:0] run_b = '0;
  logic       restart_b = 1'b0;
  logic       wr_en_b = 1'b0;
  logic [1:0] wr_chan_b = '0;
  logic [3:0] wr_data_b = '0;
  logic [2:0] clk_en_b;
  logic [2:0] inc_pending_b;

  opl3_clk_en_gen_frac #(
    .NUM_CHANNELS (3),
    .ACC_WIDTH    (4),
    .DEFAULT_INC  (4)
  ) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run_b),
    .restart     (restart_b),
    .wr_en       (wr_en_b),
    .wr_chan     (wr_chan_b),
    .wr_data     (wr_data_b),
    .clk_en      (clk_en_b),
    .inc_pending (inc_pending_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input int ch, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, ch, act, exp, $time);
  endtask

  // Compare an observed pulse cycle against the head of the expected queue.
  task automatic pulse_seen(input string name, input int ch, input int k);
    if (exp_q.size() == 0) check(name, ch, k, 0);
    else check(name, ch, k, longint'(exp_q.pop_front()));
  endtask

  task automatic queue_drained(input string name);
    check(name, 0, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Index 0 models dut_a, index 1 models dut_b.
  longint m_acc  [2][3];
  longint m_inc  [2][3];
  longint m_pend [2][3];
  bit     m_pv   [2][3];
  bit     m_en   [2][3];

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++) begin
        m_acc[d][c]  = 0;
        m_inc[d][c]  = (d == 0) ? 65536 : 4;
        m_pend[d][c] = 0;
        m_pv[d][c]   = 1'b0;
        m_en[d][c]   = 1'b0;
      end
  endtask

  task automatic model_step(input int d, input int w, input int n, input logic [2:0] run,
                            input logic rst, input logic we, input int wc, input longint wd);
    longint modulus;
    longint s;
    bit     carry;
    modulus = longint'(1) << w;
    for (int c = 0; c < n; c++) begin
      carry = 1'b0;
      if (rst) begin
        m_acc[d][c] = 0;
        m_en[d][c]  = 1'b0;
      end else if (run[c]) begin
        s = m_acc[d][c] + m_inc[d][c];
        carry = (s >= modulus);
        m_acc[d][c] = s % modulus;
        m_en[d][c]  = carry;
      end else begin
        m_en[d][c]  = 1'b0;
      end
      if (m_pv[d][c] && (rst || !run[c] || carry)) begin
        m_inc[d][c] = m_pend[d][c];
        m_pv[d][c]  = 1'b0;
      end
      if (we && wc == c) begin
        m_pend[d][c] = wd;
        m_pv[d][c]   = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      model_step(0, 24, 2, {1'b0, run_a}, restart_a, wr_en_a, int'(wr_chan_a), longint'(wr_data_a));
      model_step(1, 4, 3, run_b, restart_b, wr_en_b, int'(wr_chan_b), longint'(wr_data_b));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      for (int c = 0; c < 2; c++) begin
        check("a_clk_en", c, clk_en_a[c], m_en[0][c]);
        check("a_inc_pending", c, inc_pending_a[c], m_pv[0][c]);
      end
      for (int c = 0; c < 3; c++) begin
        check("b_clk_en", c, clk_en_b[c], m_en[1][c]);
        check("b_inc_pending", c, inc_pending_b[c], m_pv[1][c]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock: inputs set before the call are sampled at the rising edge,
  // and the caller may inspect outputs once this returns on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_b(input int ch, input int data);
    wr_en_b   = 1'b1;
    wr_chan_b = 2'(ch);
    wr_data_b = 4'(data);
  endtask

  // ---------------- directed stimulus ----------------
  int cnt0, cnt1, cnt2;
  int first [3];

  initial begin
    repeat (3) step();
    reset_n = 1'b1;

    // Reset state: default outputs are all quiet.
    check("reset_clk_en_a", 0, clk_en_a, 0);
    check("reset_inc_pending_b", 0, inc_pending_b, 0);

    // ---- 1: defaults on dut_a, pulse every 256 cycles on both channels ----
    run_a = 2'b11;
    exp_q.push_back(16'd256);
    exp_q.push_back(16'd512);
    exp_q.push_back(16'd768);
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 1; k <= 768; k++) begin
      step();
      if (clk_en_a[0]) begin
        cnt0++;
        pulse_seen("t1_ch0_pulse_cycle", 0, k);
      end
      if (clk_en_a[1]) cnt1++;
    end
    queue_drained("t1_missing_pulses");
    check("t1_ch0_count", 0, cnt0, 3);
    check("t1_ch1_count", 1, cnt1, 3);

    // ---- 2: dut_b ch1 inc=3, then restart ----
    write_b(1, 3);
    step();
    wr_en_b = 1'b0;
    check("t2_pending_after_write", 1, inc_pending_b[1], 1);
    step();
    check("t2_pending_applied_idle", 1, inc_pending_b[1], 0);
    restart_b = 1'b1;
    run_b = 3'b111;
    step();
    restart_b = 1'b0;
    check("t2_restart_quiet", 0, clk_en_b, 0);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{16'd6, 16'd11, 16'd16, 16'd22, 16'd27, 16'd32};
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (clk_en_b[1]) begin
        cnt1++;
        pulse_seen("t2_ch1_pulse_cycle", 1, k);
      end
      if (clk_en_b[0]) cnt0++;
    end
    queue_drained("t2_missing_pulses");
    check("t2_ch1_count", 1, cnt1, 6);
    check("t2_ch0_count", 0, cnt0, 8);

    // ---- 3: ch0 inc 4 -> 8 written mid-period ----
    restart_b = 1'b1;
    step();
    restart_b = 1'b0;
    exp_q = '{16'd4, 16'd8, 16'd10, 16'd12, 16'd14, 16'd16};
    for (int k = 1; k <= 16; k++) begin
      if (k == 6) write_b(0, 8);
      step();
      wr_en_b = 1'b0;
      if (clk_en_b[0]) pulse_seen("t3_ch0_pulse_cycle", 0, k);
      if (k == 6 || k == 7) check("t3_pending_held", 0, inc_pending_b[0], 1);
      if (k == 8) check("t3_pending_cleared", 0, inc_pending_b[0], 0);
    end
    queue_drained("t3_missing_pulses");

    // ---- 4: restart while channels are at different phases ----
    // ch0 inc 8, ch1 inc 3, ch2 gets inc 2 applied by the restart itself.
    repeat (4) step();
    write_b(2, 2);
    step();
    wr_en_b = 1'b0;
    restart_b = 1'b1;
    step();
    restart_b = 1'b0;
    check("t4_restart_quiet", 0, clk_en_b, 0);
    check("t4_restart_applies", 2, inc_pending_b[2], 0);
    for (int c = 0; c < 3; c++) first[c] = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      for (int c = 0; c < 3; c++)
        if (clk_en_b[c] && first[c] == 0) first[c] = k;
    end
    check("t4_first_pulse", 0, first[0], 2);
    check("t4_first_pulse", 1, first[1], 6);
    check("t4_first_pulse", 2, first[2], 8);

    // ---- 5: inc=0 written while ch2 is stopped ----
    run_b = 3'b011;
    write_b(2, 0);
    step();
    wr_en_b = 1'b0;
    check("t5_pending_after_write", 2, inc_pending_b[2], 1);
    step();
    check("t5_applied_when_stopped", 2, inc_pending_b[2], 0);
    run_b = 3'b111;
    cnt2 = 0;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (clk_en_b[2]) cnt2++;
    end
    check("t5_zero_inc_pulses", 2, cnt2, 0);
    // Out-of-range channel address is ignored.
    write_b(3, 5);
    step();
    wr_en_b = 1'b0;
    check("t5_out_of_range_write", 0, inc_pending_b, 0);

    // ---- 6: reset mid-operation with a write pending on dut_a ----
    restart_a = 1'b1;
    step();
    restart_a = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      if (k == 256) begin
        wr_en_a   = 1'b1;
        wr_chan_a = 1'b0;
        wr_data_a = 24'h100000;
      end
      step();
      wr_en_a = 1'b0;
    end
    check("t6_pulse_before_reset", 0, clk_en_a[0], 1);
    check("t6_pending_before_reset", 0, inc_pending_a[0], 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_clk_en", 0, clk_en_a, 0);
    check("t6_async_inc_pending", 0, inc_pending_a, 0);
    step();
    step();
    reset_n = 1'b1;
    exp_q = '{16'd256};
    for (int k = 1; k <= 260; k++) begin
      step();
      if (k == 1) check("t6_pending_lost", 0, inc_pending_a[0], 0);
      if (clk_en_a[0]) pulse_seen("t6_ch0_pulse_cycle", 0, k);
    end
    queue_drained("t6_missing_pulses");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/opl3_clk_en_gen_frac.md
Name: opl3_clk_en_gen_frac

Overview:
Multi-channel fractional clock-enable generator, the parametrised successor to the fixed integer-divide sample-enable scheme. Each channel uses a phase accumulator (DDS/Bresenham) to produce single-cycle enable pulses at CLK_FREQ*inc/2^ACC_WIDTH, so non-integer ratios are exact on average. Per-channel increments can be reprogrammed at runtime without glitches, and a global restart phase-aligns every channel. Used for the sample enable and for auxiliary rate enables such as timers and the DAC/LRCLK.

Parameters:
NUM_CHANNELS, 2, number of independent enable outputs (>=1)
ACC_WIDTH, 24, accumulator/increment width in bits
DEFAULT_INC, 65536, reset increment for all channels (65536 = CLK_FREQ/256 at ACC_WIDTH=24)
CHAN_SEL_WIDTH, max(1,$clog2(NUM_CHANNELS)), write-address width (derived)

Ports:
clk  in  1  master clock (12.727 MHz nominal)
reset_n  in  1  asynchronous active-low reset
run  in  NUM_CHANNELS  per-channel accumulate enable
restart  in  1  synchronous phase restart of all channels
wr_en  in  1  increment write strobe
wr_chan  in  CHAN_SEL_WIDTH  target channel for the write
wr_data  in  ACC_WIDTH  new increment value
clk_en  out  NUM_CHANNELS  registered single-cycle enable pulses
inc_pending  out  NUM_CHANNELS  written increment not yet applied

Behaviour:
- Reset (async assert, sync deassert assumed upstream): acc=0, inc=DEFAULT_INC, pending=0, pending_valid=0, clk_en=0, inc_pending=0.
- Per channel, each cycle with run=1 and restart=0: sum = acc + inc, computed at ACC_WIDTH+1 bits. acc <= sum[ACC_WIDTH-1:0]. clk_en <= sum[ACC_WIDTH] (carry).
- Output is registered: a carry computed in cycle N is visible in cycle N+1. At most one pulse per cycle per channel.
- run=0: acc holds and clk_en <= 0. Deasserting run mid-period preserves phase, and resuming continues from the held acc.
- inc=0: the channel never pulses. inc=2^ACC_WIDTH-1 pulses on all but 1 of every 2^ACC_WIDTH cycles.
- First pulse after reset or restart appears in cycle ceil(2^ACC_WIDTH/inc), counted from the first accumulating cycle as cycle 1.
- Write: when wr_en=1, pending[wr_chan] <= wr_data and pending_valid[wr_chan] <= 1. A later write before apply overwrites pending (last write wins). If wr_chan >= NUM_CHANNELS, the write is ignored.
- Apply: inc <= pending and pending_valid <= 0 in any cycle where pending_valid=1 and one of the following holds:
  (a) the channel's carry=1 (update lands on the period boundary, so there is no runt or stretched period), or
  (b) run=0, or
  (c) restart=1.
  The sum in the apply cycle uses the old inc. If a write to the same channel coincides with an apply, the old pending is applied and the new wr_data becomes pending with pending_valid=1.
- restart=1: all acc <= 0, all clk_en <= 0, and pending increments are applied (rule c). restart takes priority over run and carry. Pulses resume per the first-pulse rule from the cycle after restart.
- inc_pending = pending_valid, registered.
- Reset asserted mid-operation immediately clears everything to the reset values, including discarding pending writes.

Test Plan:
1. Defaults (ACC_WIDTH=24, inc=65536), run=all 1 after reset -> clk_en[0] pulses in cycles 256, 512, 768…; exactly 1 pulse per 256 cycles; clk_en[1] is identical.
2. ACC_WIDTH=4, write inc=3 to ch1, then restart -> ch1 pulses in cycles 6, 11, 16, 22, 27, 32…; exactly 3 pulses per 16 cycles.
3. ACC_WIDTH=4 with inc=4 running; write inc=8 mid-period -> inc_pending[ch]=1 until the next carry; periods are 4,4 then 2,2 with no short/long period at the switch; inc_pending then returns to 0.
4. restart pulsed while channels run at different phases -> all clk_en=0 that cycle; acc=0; first pulses land in cycle ceil(2^W/inc) after restart for each channel.
5. inc=0 written with run=0 -> applied immediately (inc_pending drops the next cycle); after run=1, no pulse appears over 2^W+10 cycles.
6. reset_n asserted mid-period with a write pending -> outputs go to 0 asynchronously; after release inc=DEFAULT_INC, the pending write is lost, and the first pulse occurs in cycle 256.
